// File: rtl/align_reg_out.sv
// align_reg_out: de-skews staggered systolic channel outputs and quantizes them.
// Build option: define ALIGN_REG_OUT_SAT_EN to saturate instead of wrap.
module align_reg_out #(
  parameter int REG_CHANNEL_NUM = 9,
  parameter int DATA_WIDTH_IN   = 20,
  parameter int DATA_WIDTH_OUT  = 8,
  parameter int SHIFT           = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      valid_in,
  input  logic [REG_CHANNEL_NUM*DATA_WIDTH_IN-1:0]  reg_data_in,
  input  logic [FRAME_CNT_WIDTH-1:0]                frame_len,
  output logic                                      valid_out,
  output logic [REG_CHANNEL_NUM*DATA_WIDTH_OUT-1:0] reg_data_out,
  output logic                                      last_out,
  output logic                                      busy
);

  localparam int N   = REG_CHANNEL_NUM;
  localparam int DW  = DATA_WIDTH_IN;
  localparam int DWO = DATA_WIDTH_OUT;
  localparam int FW  = FRAME_CNT_WIDTH;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [DW:0] RND =
    (SHIFT > 0) ? (DW+1)'(2**RSH) : '0;

`ifdef ALIGN_REG_OUT_SAT_EN
  localparam logic signed [DW:0] QMAX = (DW+1)'(2**(DWO-1) - 1);
  localparam logic signed [DW:0] QMIN = (DW+1)'(-(2**(DWO-1)));
`endif

  // Round half up, shift, then reduce to the output width.
  function automatic logic [DWO-1:0] quant(input logic [DW-1:0] x);
    logic signed [DW:0] s;
`ifdef ALIGN_REG_OUT_SAT_EN
    logic signed [DW:0] y;
`endif
    s = $signed({x[DW-1], x}) + RND;
`ifdef ALIGN_REG_OUT_SAT_EN
    y = s >>> SHIFT;
    if (y > QMAX)
      quant = QMAX[DWO-1:0];
    else if (y < QMIN)
      quant = QMIN[DWO-1:0];
    else
      quant = y[DWO-1:0];
`else
    quant = DWO'(s >>> SHIFT);
`endif
  endfunction

  logic [N-1:0]             vpipe;
  logic [N:0]               vch;
  logic                     aligned_v;
  logic [N-1:0][DW-1:0]     al;
  logic [N*DWO-1:0]         q_all;
  logic [FW-1:0]            cnt;
  logic [FW-1:0]            flen;
  logic [FW-1:0]            lim;
  logic                     wrap;

  // vch[k] is the valid of the beat that entered k cycles ago.
  assign vch       = {vpipe, valid_in};
  assign aligned_v = vch[N-1];
  assign valid_out = vpipe[N-1];
  assign busy      = |vpipe;

  // Valid shift register; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst)
      vpipe <= '0;
    else
      vpipe <= vch[N-1:0];
  end

  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    localparam int D = N - 1 - i;
    if (D == 0) begin : g_pass
      assign al[i] = reg_data_in[i*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] dl [D];
      // Skew-compensation delay line for this channel.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++)
            dl[k] <= '0;
        end else begin
          dl[0] <= reg_data_in[i*DW +: DW];
          for (int k = 1; k < D; k++)
            dl[k] <= dl[k-1];
        end
      end
      assign al[i] = dl[D-1];
    end
    assign q_all[i*DWO +: DWO] = quant(al[i]);
  end

  // Common output register, loaded only by valid aligned beats.
  always_ff @(posedge clk) begin
    if (rst)
      reg_data_out <= '0;
    else if (aligned_v)
      reg_data_out <= q_all;
  end

  assign flen     = (frame_len == '0) ? FW'(1) : frame_len;
  assign lim      = flen - FW'(1);
  assign wrap     = (cnt >= lim);
  assign last_out = valid_out & wrap;

  // Beat position within the frame.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (valid_out)
      cnt <= wrap ? '0 : cnt + FW'(1);
  end

endmodule
